// File: rtl/code_lock_multi.sv
`default_nettype none
// ============================================================================
// Module   : code_lock_multi
// Purpose  : Multi-digit code lock with attempt counter, 7-seg status and RGB
//            led. Optional macro LOCKOUT_TIMER_EN adds a timed alarm release.
// Revision : 1.0 - initial release
// ============================================================================
module code_lock_multi #(
   parameter int DIGIT_W   = 4,
   parameter int DIGITS    = 4,
   parameter logic [DIGIT_W*DIGITS-1:0] PASSWORD = 16'h1009,
   parameter int MAX_TRIES = 4
`ifdef LOCKOUT_TIMER_EN
   ,
   parameter int LOCKOUT_CYC = 100000000
`endif
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               key_pulse,
   input  logic               clear,
   input  logic [DIGIT_W-1:0] code,
   output logic [3:0]         tries_left,
   output logic               unlocked,
   output logic               alarm,
   output logic [8:0]         sega,
   output logic [8:0]         segb,
   output logic [2:0]         RGB_led
);

   localparam int         EW       = DIGIT_W * DIGITS;
   localparam logic [3:0] IDX_LAST = 4'(DIGITS - 1);
   localparam logic [3:0] TRIES0   = 4'(MAX_TRIES);

   typedef enum logic [1:0] {
      S_ENTRY = 2'd0,
      S_CHECK = 2'd1,
      S_OPEN  = 2'd2,
      S_ALARM = 2'd3
   } state_t;

   function automatic logic [8:0] f_seg(input logic [3:0] v);
      case (v)
         4'd0:    f_seg = 9'h03f;
         4'd1:    f_seg = 9'h006;
         4'd2:    f_seg = 9'h05b;
         4'd3:    f_seg = 9'h04f;
         4'd4:    f_seg = 9'h066;
         4'd5:    f_seg = 9'h06d;
         4'd6:    f_seg = 9'h07d;
         4'd7:    f_seg = 9'h007;
         4'd8:    f_seg = 9'h07f;
         4'd9:    f_seg = 9'h06f;
         default: f_seg = 9'h040;
      endcase
   endfunction

   state_t          r_state;
   logic [EW-1:0]   r_entry;
   logic [3:0]      r_idx;
   logic [3:0]      r_tries;
   logic            r_unlocked;
   logic            r_alarm;
   logic [8:0]      r_sega;
   logic [8:0]      r_segb;
   logic [2:0]      r_rgb;
   logic [3:0]      w_tries_dec;

`ifdef LOCKOUT_TIMER_EN
   localparam int      CW       = $clog2(LOCKOUT_CYC + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(LOCKOUT_CYC - 1);
   logic [CW-1:0]      r_cnt;
`endif

   // Saturating decrement: the attempt counter never wraps below zero.
   assign w_tries_dec = (r_tries == 4'd0) ? 4'd0 : r_tries - 4'd1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_ENTRY;
         r_entry    <= '0;
         r_idx      <= 4'd0;
         r_tries    <= TRIES0;
         r_unlocked <= 1'b0;
         r_alarm    <= 1'b0;
         r_rgb      <= 3'b111;
         r_sega     <= 9'h03f;
         r_segb     <= f_seg(TRIES0);
`ifdef LOCKOUT_TIMER_EN
         r_cnt      <= '0;
`endif
      end else begin
         case (r_state)
            S_ENTRY: begin
               if (clear) begin
                  r_entry <= '0;
                  r_idx   <= 4'd0;
                  r_sega  <= 9'h03f;
               end else if (key_pulse) begin
                  r_entry <= (r_entry << DIGIT_W) | EW'(code);
                  if (r_idx == IDX_LAST) begin
                     r_idx   <= 4'd0;
                     r_sega  <= 9'h03f;
                     r_state <= S_CHECK;
                  end else begin
                     r_idx  <= r_idx + 4'd1;
                     r_sega <= f_seg(r_idx + 4'd1);
                  end
               end
            end
            S_CHECK: begin
               r_entry <= '0;
               if (r_entry == PASSWORD) begin
                  r_state    <= S_OPEN;
                  r_unlocked <= 1'b1;
                  r_rgb      <= 3'b000;
                  r_sega     <= 9'h040;
                  r_segb     <= 9'h040;
               end else if (w_tries_dec == 4'd0) begin
                  r_state <= S_ALARM;
                  r_tries <= 4'd0;
                  r_alarm <= 1'b1;
                  r_rgb   <= 3'b010;
                  r_sega  <= 9'h040;
                  r_segb  <= 9'h03f;
`ifdef LOCKOUT_TIMER_EN
                  r_cnt   <= '0;
`endif
               end else begin
                  r_state <= S_ENTRY;
                  r_tries <= w_tries_dec;
                  r_sega  <= 9'h03f;
                  r_segb  <= f_seg(w_tries_dec);
               end
            end
            S_OPEN: begin
               if (clear) begin
                  r_state    <= S_ENTRY;
                  r_tries    <= TRIES0;
                  r_unlocked <= 1'b0;
                  r_rgb      <= 3'b111;
                  r_sega     <= 9'h03f;
                  r_segb     <= f_seg(TRIES0);
               end
            end
            S_ALARM: begin
`ifdef LOCKOUT_TIMER_EN
               if (r_cnt == CNT_LAST) begin
                  r_state <= S_ENTRY;
                  r_cnt   <= '0;
                  r_tries <= TRIES0;
                  r_alarm <= 1'b0;
                  r_rgb   <= 3'b111;
                  r_sega  <= 9'h03f;
                  r_segb  <= f_seg(TRIES0);
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
`endif
            end
            default: r_state <= S_ENTRY;
         endcase
      end
   end

   assign tries_left = r_tries;
   assign unlocked   = r_unlocked;
   assign alarm      = r_alarm;
   assign sega       = r_sega;
   assign segb       = r_segb;
   assign RGB_led    = r_rgb;

endmodule
`default_nettype wire

// File: tb/tb_code_lock_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_code_lock_multi
// Purpose  : Directed self-checking bench for code_lock_multi.
// Revision : 1.0 - initial release
// ============================================================================
module tb_code_lock_multi;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       key_pulse = 1'b0;
   logic       clear = 1'b0;
   logic [3:0] code = 4'd0;
   logic [3:0] tries_left;
   logic       unlocked;
   logic       alarm;
   logic [8:0] sega;
   logic [8:0] segb;
   logic [2:0] RGB_led;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

`ifdef LOCKOUT_TIMER_EN
   code_lock_multi #(.DIGIT_W(4), .DIGITS(4), .PASSWORD(16'h1009), .MAX_TRIES(4),
                     .LOCKOUT_CYC(20)) dut (
`else
   code_lock_multi #(.DIGIT_W(4), .DIGITS(4), .PASSWORD(16'h1009), .MAX_TRIES(4)) dut (
`endif
      .clk(clk), .rst(rst), .key_pulse(key_pulse), .clear(clear), .code(code),
      .tries_left(tries_left), .unlocked(unlocked), .alarm(alarm),
      .sega(sega), .segb(segb), .RGB_led(RGB_led)
   );

   // Input changes on the falling edge; returns on the next falling edge.
   task automatic press(input logic [3:0] d);
      @(negedge clk);
      code = d; key_pulse = 1'b1;
      @(negedge clk);
      key_pulse = 1'b0;
   endtask

   task automatic do_clear();
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   // Leaves the lock in CHECK; one more falling edge shows the verdict.
   task automatic enter_code(input logic [15:0] c);
      press(c[15:12]); press(c[11:8]); press(c[7:4]); press(c[3:0]);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (tries_left !== 4'd4) begin n_err++; $display("FAIL reset_tries got %0d want 4", tries_left); end
      n_cmp++; if (unlocked !== 1'b0 || alarm !== 1'b0) begin n_err++; $display("FAIL reset_flags got %b%b want 00", unlocked, alarm); end
      n_cmp++; if (RGB_led !== 3'b111) begin n_err++; $display("FAIL reset_rgb got %b want 111", RGB_led); end
      n_cmp++; if (sega !== 9'h03f || segb !== 9'h066) begin n_err++; $display("FAIL reset_seg got %h/%h want 03f/066", sega, segb); end
   endtask

   task automatic test_unlock();
      press(4'd1);
      n_cmp++; if (sega !== 9'h006) begin n_err++; $display("FAIL unlock_sega1 got %h want 006", sega); end
      press(4'd0);
      n_cmp++; if (sega !== 9'h05b) begin n_err++; $display("FAIL unlock_sega2 got %h want 05b", sega); end
      press(4'd0); press(4'd9);
      n_cmp++; if (unlocked !== 1'b0) begin n_err++; $display("FAIL unlock_early got %b want 0", unlocked); end
      @(negedge clk);
      n_cmp++; if (unlocked !== 1'b1 || RGB_led !== 3'b000) begin n_err++; $display("FAIL unlock_open got %b/%b want 1/000", unlocked, RGB_led); end
      n_cmp++; if (sega !== 9'h040 || segb !== 9'h040) begin n_err++; $display("FAIL unlock_seg got %h/%h want 040/040", sega, segb); end
      press(4'd3);
      n_cmp++; if (unlocked !== 1'b1 || sega !== 9'h040) begin n_err++; $display("FAIL open_keyignored got %b/%h want 1/040", unlocked, sega); end
      do_clear();
      n_cmp++; if (unlocked !== 1'b0 || RGB_led !== 3'b111 || segb !== 9'h066 || sega !== 9'h03f)
         begin n_err++; $display("FAIL relock got %b/%b/%h/%h want 0/111/066/03f", unlocked, RGB_led, segb, sega); end
   endtask

   task automatic test_wrong();
      enter_code(16'h1008);
      @(negedge clk);
      n_cmp++; if (tries_left !== 4'd3 || segb !== 9'h04f) begin n_err++; $display("FAIL wrong_tries got %0d/%h want 3/04f", tries_left, segb); end
      n_cmp++; if (sega !== 9'h03f || unlocked !== 1'b0 || RGB_led !== 3'b111) begin n_err++; $display("FAIL wrong_state got %h/%b/%b want 03f/0/111", sega, unlocked, RGB_led); end
      press(4'd5);
      n_cmp++; if (sega !== 9'h006) begin n_err++; $display("FAIL wrong_reentry got %h want 006", sega); end
      do_clear();
      n_cmp++; if (sega !== 9'h03f || tries_left !== 4'd3) begin n_err++; $display("FAIL wrong_clear got %h/%0d want 03f/3", sega, tries_left); end
   endtask

   task automatic test_clear_abort();
      do_reset();
      press(4'd1); press(4'd0);
      do_clear();
      enter_code(16'h1009);
      @(negedge clk);
      n_cmp++; if (unlocked !== 1'b1 || tries_left !== 4'd4) begin n_err++; $display("FAIL abort_unlock got %b/%0d want 1/4", unlocked, tries_left); end
      do_clear();
   endtask

   task automatic test_clear_and_key();
      press(4'd1);
      @(negedge clk);
      code = 4'd0; key_pulse = 1'b1; clear = 1'b1;
      @(negedge clk);
      key_pulse = 1'b0; clear = 1'b0;
      n_cmp++; if (sega !== 9'h03f) begin n_err++; $display("FAIL clrkey_sega got %h want 03f", sega); end
      enter_code(16'h1009);
      @(negedge clk);
      n_cmp++; if (unlocked !== 1'b1) begin n_err++; $display("FAIL clrkey_unlock got %b want 1", unlocked); end
      do_clear();
   endtask

   task automatic test_mid_reset();
      press(4'd1); press(4'd0);
      @(negedge clk);
      rst = 1'b0;
      #2;
      n_cmp++; if (sega !== 9'h03f || tries_left !== 4'd4) begin n_err++; $display("FAIL midrst got %h/%0d want 03f/4", sega, tries_left); end
      @(negedge clk);
      rst = 1'b1;
      enter_code(16'h1009);
      @(negedge clk);
      n_cmp++; if (unlocked !== 1'b1) begin n_err++; $display("FAIL midrst_unlock got %b want 1", unlocked); end
      do_reset();
   endtask

   task automatic test_alarm();
      do_reset();
      enter_code(16'h1008); @(negedge clk);
      enter_code(16'h2222); @(negedge clk);
      enter_code(16'h9001); @(negedge clk);
      n_cmp++; if (tries_left !== 4'd1 || segb !== 9'h006 || alarm !== 1'b0) begin n_err++; $display("FAIL alarm_pre got %0d/%h/%b want 1/006/0", tries_left, segb, alarm); end
      enter_code(16'h0000); @(negedge clk);
      n_cmp++; if (alarm !== 1'b1 || RGB_led !== 3'b010) begin n_err++; $display("FAIL alarm_on got %b/%b want 1/010", alarm, RGB_led); end
      n_cmp++; if (tries_left !== 4'd0 || segb !== 9'h03f || sega !== 9'h040) begin n_err++; $display("FAIL alarm_disp got %0d/%h/%h want 0/03f/040", tries_left, segb, sega); end
      enter_code(16'h1009); @(negedge clk);
      do_clear();
      n_cmp++; if (alarm !== 1'b1 || unlocked !== 1'b0 || tries_left !== 4'd0) begin n_err++; $display("FAIL alarm_hold got %b/%b/%0d want 1/0/0", alarm, unlocked, tries_left); end
      do_reset();
      n_cmp++; if (alarm !== 1'b0 || tries_left !== 4'd4 || RGB_led !== 3'b111) begin n_err++; $display("FAIL alarm_rst got %b/%0d/%b want 0/4/111", alarm, tries_left, RGB_led); end
   endtask

`ifdef LOCKOUT_TIMER_EN
   task automatic test_lockout();
      int cyc;
      do_reset();
      for (int k = 0; k < 4; k++) begin
         enter_code(16'h4321);
         @(negedge clk);
      end
      cyc = 0;
      while (alarm === 1'b1 && cyc < 100) begin
         cyc++;
         @(negedge clk);
      end
      n_cmp++; if (cyc !== 20) begin n_err++; $display("FAIL lockout_len got %0d want 20", cyc); end
      n_cmp++; if (tries_left !== 4'd4 || RGB_led !== 3'b111 || segb !== 9'h066) begin n_err++; $display("FAIL lockout_exit got %0d/%b/%h want 4/111/066", tries_left, RGB_led, segb); end
      enter_code(16'h1009); @(negedge clk);
      n_cmp++; if (unlocked !== 1'b1) begin n_err++; $display("FAIL lockout_reentry got %b want 1", unlocked); end
   endtask
`endif

   initial begin
      test_reset();
      test_unlock();
      test_wrong();
      test_clear_abort();
      test_clear_and_key();
      test_mid_reset();
      test_alarm();
`ifdef LOCKOUT_TIMER_EN
      test_lockout();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
